// File: rtl/sos_stage_scheduler_if.sv
// rtl/sos_stage_scheduler_if.sv - link between the stage scheduler and the shared SOS datapath
interface sos_stage_scheduler_if #(
    parameter int DATA_SIZE = 24,
    parameter int SEL_SIZE  = 1
);
    logic                 stage_start;
    logic [SEL_SIZE-1:0]  stage_sel;
    logic [DATA_SIZE-1:0] stage_data_in;
    logic [DATA_SIZE-1:0] stage_data_out;
    logic                 stage_done;

    modport master (
        output stage_start,
        output stage_sel,
        output stage_data_in,
        input  stage_data_out,
        input  stage_done
    );

    modport slave (
        input  stage_start,
        input  stage_sel,
        input  stage_data_in,
        output stage_data_out,
        output stage_done
    );
endinterface

// File: rtl/sos_stage_scheduler.sv
// rtl/sos_stage_scheduler.sv - walks one sample through NUM_STAGES passes of a shared biquad datapath
module sos_stage_scheduler #(
    parameter int DATA_SIZE  = 24,
    parameter int NUM_STAGES = 2,
    parameter int SEL_SIZE   = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sample_trig,
    input  logic [DATA_SIZE-1:0] i_data_in,
    sos_stage_scheduler_if.master dp,
    output logic [DATA_SIZE-1:0] o_data_out,
    output logic                 o_filter_done,
    output logic                 o_busy,
    output logic                 o_overrun,
    output logic                 o_timeout
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [SEL_SIZE-1:0] SEL_LAST   = SEL_SIZE'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [SEL_SIZE-1:0]  r_sel;
    logic [DATA_SIZE-1:0] r_stage_data;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_filter_done;
    logic                 r_overrun;
    logic                 r_timeout;
    logic [WD_W-1:0]      r_wd;

    logic w_last_stage;
    logic w_wd_expired;
    logic w_start;
    logic w_busy;

    assign w_last_stage = (r_sel == SEL_LAST);
    assign w_wd_expired = (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // stage_done beats a watchdog expiry in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_sample_trig) w_next = ST_LAUNCH;
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                if (dp.stage_done) begin
                    w_next = w_last_stage ? ST_IDLE : ST_LAUNCH;
                end else if (w_wd_expired) begin
                    w_next = ST_IDLE;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start = (r_state == ST_LAUNCH);
        w_busy  = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel         <= '0;
            r_stage_data  <= '0;
            r_data_out    <= '0;
            r_filter_done <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_filter_done <= 1'b0;
            if (i_sample_trig && w_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_sample_trig) begin
                        r_stage_data <= i_data_in;
                        r_sel        <= '0;
                    end
                end
                ST_LAUNCH: r_wd <= '0;
                ST_WAIT: begin
                    if (dp.stage_done) begin
                        if (w_last_stage) begin
                            r_data_out    <= dp.stage_data_out;
                            r_filter_done <= 1'b1;
                            r_sel         <= '0;
                        end else begin
                            r_stage_data <= dp.stage_data_out;
                            r_sel        <= r_sel + SEL_SIZE'(1);
                        end
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_sel     <= '0;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dp.stage_start   = w_start;
    assign dp.stage_sel     = r_sel;
    assign dp.stage_data_in = r_stage_data;
    assign o_data_out       = r_data_out;
    assign o_filter_done    = r_filter_done;
    assign o_busy           = w_busy;
    assign o_overrun        = r_overrun;
    assign o_timeout        = r_timeout;
endmodule

// File: tb/tb_sos_stage_scheduler.sv
// tb/tb_sos_stage_scheduler.sv - directed bench for sos_stage_scheduler with a behavioural datapath
module tb_sos_stage_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    // DUT a: two stages; DUT b: one stage; both TIMEOUT=8
    logic        trig_a = 1'b0, trig_b = 1'b0;
    logic [23:0] din_a = '0, din_b = '0;
    logic [23:0] dout_a, dout_b;
    logic        fd_a, fd_b, busy_a, busy_b, ov_a, ov_b, to_a, to_b;

    sos_stage_scheduler_if #(.DATA_SIZE(24), .SEL_SIZE(1)) ifa ();
    sos_stage_scheduler_if #(.DATA_SIZE(24), .SEL_SIZE(1)) ifb ();

    sos_stage_scheduler #(.DATA_SIZE(24), .NUM_STAGES(2), .SEL_SIZE(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset), .i_sample_trig(trig_a), .i_data_in(din_a), .dp(ifa),
        .o_data_out(dout_a), .o_filter_done(fd_a), .o_busy(busy_a), .o_overrun(ov_a), .o_timeout(to_a)
    );

    sos_stage_scheduler #(.DATA_SIZE(24), .NUM_STAGES(1), .SEL_SIZE(1), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .i_sample_trig(trig_b), .i_data_in(din_b), .dp(ifb),
        .o_data_out(dout_b), .o_filter_done(fd_b), .o_busy(busy_b), .o_overrun(ov_b), .o_timeout(to_b)
    );

    // Datapath model: done L cycles after start, result = operand + stage_sel + 1
    int          lat_a = 3, lat_b = 1;
    logic        en_a = 1'b1, en_b = 1'b1;
    logic        pend_a = 1'b0, pend_b = 1'b0;
    int          due_a = 0, due_b = 0;
    logic [23:0] op_a = '0, op_b = '0;
    logic        sel_a = 1'b0, sel_b = 1'b0;

    assign ifa.stage_done     = en_a && pend_a && (cyc == due_a);
    assign ifa.stage_data_out = op_a + {23'd0, sel_a} + 24'd1;
    assign ifb.stage_done     = en_b && pend_b && (cyc == due_b);
    assign ifb.stage_data_out = op_b + {23'd0, sel_b} + 24'd1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifa.stage_start) begin
            pend_a <= 1'b1; due_a <= cyc + lat_a; op_a <= ifa.stage_data_in; sel_a <= ifa.stage_sel;
        end else if (ifa.stage_done) begin
            pend_a <= 1'b0;
        end
        if (ifb.stage_start) begin
            pend_b <= 1'b1; due_b <= cyc + lat_b; op_b <= ifb.stage_data_in; sel_b <= ifb.stage_sel;
        end else if (ifb.stage_done) begin
            pend_b <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (ifa.stage_start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b expected 0", ifa.stage_start); end
        n_checks++; if (ifa.stage_sel !== 1'b0) begin n_errors++; $display("FAIL reset_sel: got %b expected 0", ifa.stage_sel); end
        n_checks++; if (ifa.stage_data_in !== 24'h0) begin n_errors++; $display("FAIL reset_stage_data_in: got %h expected 000000", ifa.stage_data_in); end
        n_checks++; if (dout_a !== 24'h0) begin n_errors++; $display("FAIL reset_data_out: got %h expected 000000", dout_a); end
        n_checks++; if ({fd_a, busy_a, ov_a, to_a} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {fd_a, busy_a, ov_a, to_a}); end
        n_checks++; if ({fd_b, busy_b, ov_b, to_b, ifb.stage_start} !== 5'b0) begin n_errors++; $display("FAIL reset_flags_b: got %b expected 00000", {fd_b, busy_b, ov_b, to_b, ifb.stage_start}); end
    endtask

    task automatic test_basic();
        int n_start = 0, s1 = -1, s2 = -1, done_k = -1;
        logic sel1 = 1'b1, sel2 = 1'b0;
        logic [23:0] res = '0;
        lat_a = 3; en_a = 1'b1;
        trig_a = 1'b1; din_a = 24'h000100;
        for (int k = 1; k <= 9; k++) begin
            tick(); trig_a = 1'b0;
            if (ifa.stage_start) begin
                if (n_start == 0) begin s1 = k; sel1 = ifa.stage_sel; end
                else begin s2 = k; sel2 = ifa.stage_sel; end
                n_start++;
            end
            if (fd_a && done_k < 0) begin done_k = k; res = dout_a; end
        end
        n_checks++; if (n_start != 2) begin n_errors++; $display("FAIL basic_start_count: got %0d expected 2", n_start); end
        n_checks++; if (s1 != 1 || s2 != 5) begin n_errors++; $display("FAIL basic_start_cycles: got %0d,%0d expected 1,5", s1, s2); end
        n_checks++; if (sel1 !== 1'b0 || sel2 !== 1'b1) begin n_errors++; $display("FAIL basic_stage_sel: got %b,%b expected 0,1", sel1, sel2); end
        n_checks++; if (done_k != 9) begin n_errors++; $display("FAIL basic_done_cycle: got %0d expected 9", done_k); end
        n_checks++; if (res !== 24'h000103) begin n_errors++; $display("FAIL basic_data_out: got %h expected 000103", res); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_a); end
    endtask

    task automatic test_back_to_back();
        int n_start = 0, done_k = -1;
        logic ov_seen = 1'b0;
        n_checks++; if (fd_a !== 1'b1) begin n_errors++; $display("FAIL b2b_in_done_cycle: got %b expected 1", fd_a); end
        trig_a = 1'b1; din_a = 24'h000200;
        for (int k = 1; k <= 9; k++) begin
            tick(); trig_a = 1'b0;
            if (ifa.stage_start) n_start++;
            if (ov_a) ov_seen = 1'b1;
            if (fd_a && done_k < 0) done_k = k;
        end
        n_checks++; if (ov_seen !== 1'b0) begin n_errors++; $display("FAIL b2b_overrun: got %b expected 0", ov_seen); end
        n_checks++; if (n_start != 2 || done_k != 9) begin n_errors++; $display("FAIL b2b_timing: got starts=%0d done=%0d expected 2,9", n_start, done_k); end
        n_checks++; if (dout_a !== 24'h000203) begin n_errors++; $display("FAIL b2b_data_out: got %h expected 000203", dout_a); end
    endtask

    task automatic test_overrun();
        int n_start = 0, done_k = -1;
        logic ov4 = 1'b1, ov5 = 1'b0;
        logic [23:0] res = '0;
        tick(); tick();
        trig_a = 1'b1; din_a = 24'h000010;
        for (int k = 1; k <= 12; k++) begin
            tick(); trig_a = 1'b0;
            if (k == 4) begin ov4 = ov_a; trig_a = 1'b1; din_a = 24'h000555; end
            if (k == 5) ov5 = ov_a;
            if (ifa.stage_start) n_start++;
            if (fd_a && done_k < 0) begin done_k = k; res = dout_a; end
        end
        n_checks++; if (ov4 !== 1'b0 || ov5 !== 1'b1) begin n_errors++; $display("FAIL overrun_flag: got T+4=%b T+5=%b expected 0,1", ov4, ov5); end
        n_checks++; if (n_start != 2) begin n_errors++; $display("FAIL overrun_start_count: got %0d expected 2", n_start); end
        n_checks++; if (done_k != 9 || res !== 24'h000013) begin n_errors++; $display("FAIL overrun_result: got k=%0d data=%h expected 9,000013", done_k, res); end
    endtask

    task automatic test_timeout();
        logic to9 = 1'b1, to10 = 1'b0, busy10 = 1'b1, fd_seen = 1'b0;
        int done_k = -1;
        en_a = 1'b0;
        trig_a = 1'b1; din_a = 24'h000777;
        for (int k = 1; k <= 14; k++) begin
            tick(); trig_a = 1'b0;
            if (k == 9) to9 = to_a;
            if (k == 10) begin to10 = to_a; busy10 = busy_a; end
            if (fd_a) fd_seen = 1'b1;
        end
        n_checks++; if (to9 !== 1'b0 || to10 !== 1'b1) begin n_errors++; $display("FAIL timeout_flag: got T+9=%b T+10=%b expected 0,1", to9, to10); end
        n_checks++; if (busy10 !== 1'b0) begin n_errors++; $display("FAIL timeout_busy: got %b expected 0", busy10); end
        n_checks++; if (fd_seen !== 1'b0) begin n_errors++; $display("FAIL timeout_filter_done: got %b expected 0", fd_seen); end
        n_checks++; if (dout_a !== 24'h000013) begin n_errors++; $display("FAIL timeout_data_hold: got %h expected 000013", dout_a); end
        en_a = 1'b1;
        trig_a = 1'b1; din_a = 24'h000020;
        for (int k = 1; k <= 9; k++) begin
            tick(); trig_a = 1'b0;
            if (fd_a && done_k < 0) done_k = k;
        end
        n_checks++; if (done_k != 9 || dout_a !== 24'h000023) begin n_errors++; $display("FAIL timeout_recover: got k=%0d data=%h expected 9,000023", done_k, dout_a); end
        n_checks++; if (to_a !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: got %b expected 1", to_a); end
    endtask

    task automatic test_reset_mid_wait();
        logic fd_seen = 1'b0, late_done = 1'b0;
        tick(); tick();
        trig_a = 1'b1; din_a = 24'h000030;
        for (int k = 1; k <= 12; k++) begin
            tick(); trig_a = 1'b0;
            if (k == 6) reset = 1'b1;
            if (k == 7) begin
                reset = 1'b0;
                n_checks++;
                if ({ifa.stage_start, ifa.stage_sel, busy_a, fd_a, ov_a, to_a} !== 6'b0 ||
                    ifa.stage_data_in !== 24'h0 || dout_a !== 24'h0) begin
                    n_errors++;
                    $display("FAIL midreset_outputs: got flags=%b sdi=%h dout=%h expected 000000,000000,000000",
                             {ifa.stage_start, ifa.stage_sel, busy_a, fd_a, ov_a, to_a}, ifa.stage_data_in, dout_a);
                end
            end
            if (k == 8) late_done = ifa.stage_done;
            if (k >= 7 && fd_a) fd_seen = 1'b1;
        end
        n_checks++; if (late_done !== 1'b1) begin n_errors++; $display("FAIL midreset_late_done_present: got %b expected 1", late_done); end
        n_checks++; if (fd_seen !== 1'b0 || dout_a !== 24'h0 || busy_a !== 1'b0) begin n_errors++; $display("FAIL midreset_ignored: got fd=%b dout=%h busy=%b expected 0,000000,0", fd_seen, dout_a, busy_a); end
    endtask

    task automatic test_edges();
        int n_start = 0, done_k = -1;
        logic done9 = 1'b0;
        lat_b = 1;
        trig_b = 1'b1; din_b = 24'h000040;
        for (int k = 1; k <= 5; k++) begin
            tick(); trig_b = 1'b0;
            if (ifb.stage_start) n_start++;
            if (fd_b && done_k < 0) done_k = k;
        end
        n_checks++; if (done_k != 3 || n_start != 1) begin n_errors++; $display("FAIL edge_n1_timing: got done=%0d starts=%0d expected 3,1", done_k, n_start); end
        n_checks++; if (dout_b !== 24'h000041) begin n_errors++; $display("FAIL edge_n1_data: got %h expected 000041", dout_b); end
        lat_b = 8; done_k = -1;
        tick();
        trig_b = 1'b1; din_b = 24'h000050;
        for (int k = 1; k <= 12; k++) begin
            tick(); trig_b = 1'b0;
            if (k == 9) done9 = ifb.stage_done;
            if (fd_b && done_k < 0) done_k = k;
        end
        n_checks++; if (done9 !== 1'b1 || done_k != 10) begin n_errors++; $display("FAIL edge_expiry_race_timing: got done9=%b fd=%0d expected 1,10", done9, done_k); end
        n_checks++; if (to_b !== 1'b0 || dout_b !== 24'h000051) begin n_errors++; $display("FAIL edge_expiry_race_result: got to=%b data=%h expected 0,000051", to_b, dout_b); end
    endtask

    initial begin
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_mid_wait();
        test_edges();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
